// File: rtl/cnt_trace_fifo.sv
// rtl/cnt_trace_fifo.sv - timestamped change trace of a counter through a small valid/ready FIFO
// Optional gap tagging is compiled in with `define CNT_TRACE_GAP_CHECK_EN.
module cnt_trace_fifo #(
    parameter int CNT_W = 3,
    parameter int TS_W  = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt_in,
    input  logic             done_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_done,
    output logic [TS_W-1:0]  out_stamp,
    output logic             out_gap,
    output logic [7:0]       wrap_count,
    output logic             overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [TS_W-1:0]  ts;
    logic [CNT_W-1:0] prev;
    logic             primed;

    logic [CNT_W-1:0] mem_cnt   [DEPTH];
    logic             mem_done  [DEPTH];
    logic [TS_W-1:0]  mem_stamp [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic sample_event;
    logic wrap_seen;
    logic full;
    logic pop;
    logic push;

    assign sample_event = !primed || (cnt_in != prev);
    assign wrap_seen    = primed && (prev == CNT_MAX) && (cnt_in == '0);
    assign full         = (count == FULL_COUNT);
    assign out_valid    = (count != '0);
    assign pop          = out_valid && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push         = sample_event && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts     <= '0;
            prev   <= '0;
            primed <= 1'b0;
        end else begin
            ts     <= ts + 1'b1;
            prev   <= cnt_in;
            primed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; outputs are gated by out_valid so stale contents never show.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_cnt[wr_ptr]   <= cnt_in;
            mem_done[wr_ptr]  <= done_in;
            mem_stamp[wr_ptr] <= ts;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wrap_seen && (wrap_count != 8'hFF)) begin
                wrap_count <= wrap_count + 1'b1;
            end
            if (sample_event && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign out_cnt   = out_valid ? mem_cnt[rd_ptr]   : '0;
    assign out_done  = out_valid ? mem_done[rd_ptr]  : 1'b0;
    assign out_stamp = out_valid ? mem_stamp[rd_ptr] : '0;

`ifdef CNT_TRACE_GAP_CHECK_EN
    logic             mem_gap [DEPTH];
    logic [CNT_W-1:0] prev_inc;
    logic             gap_bit;

    // Modulo increment, so max->0 counts as in-sequence.
    assign prev_inc = prev + 1'b1;
    assign gap_bit  = primed && (cnt_in != prev_inc);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_gap[wr_ptr] <= gap_bit;
        end
    end

    assign out_gap = out_valid ? mem_gap[rd_ptr] : 1'b0;
`else
    assign out_gap = 1'b0;
`endif

endmodule
